cpu_ctrl: RTL and testbench

Multi-cycle control unit for the 4-bit CPU, directly upstream of reg_file. It fetches 10-bit instructions from a 16-entry instruction memory and decodes them. It then drives reg_file's SEL_A/SEL_B/SEL_W, the ALU op, and the write-back mux/enable through a FETCH/DECODE/EXEC/WRITE state machine. It owns the PC and the zero flag.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/cpu_decode.sv | 57 +++++
 rtl/cpu_ctrl.sv | 105 ++++++++++
 tb/tb_cpu_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg: opcodes, ALU codes, FSM encoding and instruction fields for cpu_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 2;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       wb_sel;
    logic       writes_reg;
    logic       is_jmp;
    logic       is_jz;
    logic       is_halt;
    logic       zf_upd;
  } decode_t;

endpackage

`default_nettype wire

// File: rtl/cpu_decode.sv
// ============================================================================
// cpu_decode: combinational opcode decoder feeding the cpu_ctrl FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  output decode_t    dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_ADD;
    case (op_i)
      OP_LDI: begin
        dec_o.alu_op     = ALU_PASSB;
        dec_o.wb_sel     = 1'b1;
        dec_o.writes_reg = 1'b1;
      end
      OP_MOV: begin
        dec_o.alu_op     = ALU_PASSB;
        dec_o.writes_reg = 1'b1;
      end
      OP_ADD: begin
        dec_o.alu_op     = ALU_ADD;
        dec_o.writes_reg = 1'b1;
        dec_o.zf_upd     = 1'b1;
      end
      OP_SUB: begin
        dec_o.alu_op     = ALU_SUB;
        dec_o.writes_reg = 1'b1;
        dec_o.zf_upd     = 1'b1;
      end
      OP_AND: begin
        dec_o.alu_op     = ALU_AND;
        dec_o.writes_reg = 1'b1;
        dec_o.zf_upd     = 1'b1;
      end
      OP_OR: begin
        dec_o.alu_op     = ALU_OR;
        dec_o.writes_reg = 1'b1;
        dec_o.zf_upd     = 1'b1;
      end
      OP_JMP:  dec_o.is_jmp  = 1'b1;
      OP_JZ:   dec_o.is_jz   = 1'b1;
      OP_HALT: dec_o.is_halt = 1'b1;
      // NOP and the unused opcodes 9-E fall through as no-operation
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
// cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/WRITE control unit; owns pc, ir, z
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               alu_zero_i,
  output logic [1:0]         sel_a_o,
  output logic [1:0]         sel_b_o,
  output logic [1:0]         sel_w_o,
  output logic               reg_we_o,
  output logic               wb_sel_o,
  output logic [3:0]         imm_o,
  output logic [2:0]         alu_op_o,
  output logic               halted_o
);

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               z_q, z_d;

  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [3:0] w_imm;
  decode_t    w_dec;

  assign w_op  = ir_q[OP_MSB:OP_LSB];
  assign w_rd  = ir_q[RD_MSB:RD_LSB];
  assign w_rs  = ir_q[RS_MSB:RS_LSB];
  assign w_imm = ir_q[IMM_MSB:IMM_LSB];

  cpu_decode u_decode (
    .op_i  (w_op),
    .dec_o (w_dec)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    if (en_i) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          ir_d    = imem_data_i;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (w_dec.zf_upd) z_d = alu_zero_i;
          // Jumps overwrite the pc that was already advanced in DECODE
          if (w_dec.is_jmp || (w_dec.is_jz && z_q)) pc_d = PC_W'(w_imm);
          if (w_dec.is_halt)         state_d = S_HALT;
          else if (w_dec.writes_reg) state_d = S_WRITE;
          else                       state_d = S_FETCH;
        end
        S_WRITE: state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  // Selects come straight from ir so they stay defined and stable through WRITE
  assign imem_addr_o = pc_q;
  assign sel_a_o     = w_rd;
  assign sel_b_o     = w_rs;
  assign sel_w_o     = w_rd;
  assign imm_o       = w_imm;
  assign alu_op_o    = w_dec.alu_op;
  assign wb_sel_o    = w_dec.wb_sel;
  assign reg_we_o    = (state_q == S_WRITE) && en_i;
  assign halted_o    = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ============================================================================
// tb_cpu_ctrl: directed self-checking bench for cpu_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       en_i = 1'b1;
  logic [3:0] imem_addr_o;
  logic [9:0] imem_data_i = '0;
  logic       alu_zero_i = 1'b0;
  logic [1:0] sel_a_o, sel_b_o, sel_w_o;
  logic       reg_we_o, wb_sel_o, halted_o;
  logic [3:0] imm_o;
  logic [2:0] alu_op_o;

  logic [9:0] mem [16];
  int n_checks = 0;
  int n_pass   = 0;

  cpu_ctrl #(.PC_W(4), .INSTR_W(10)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (en_i),
    .imem_addr_o (imem_addr_o),
    .imem_data_i (imem_data_i),
    .alu_zero_i  (alu_zero_i),
    .sel_a_o     (sel_a_o),
    .sel_b_o     (sel_b_o),
    .sel_w_o     (sel_w_o),
    .reg_we_o    (reg_we_o),
    .wb_sel_o    (wb_sel_o),
    .imm_o       (imm_o),
    .alu_op_o    (alu_op_o),
    .halted_o    (halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read instruction memory: data valid the cycle after the address
  always @(posedge clk_i) imem_data_i <= mem[imem_addr_o];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 10'h000;
  endtask

  // Leaves the bench 1 time unit after an edge with the DUT in FETCH (cycle 1)
  task automatic do_reset();
    rst_n_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    rst_n_i = 1'b0;
    #1;
    n_checks++; if (imem_addr_o !== 4'd0) $display("FAIL reset_addr got %0d want 0", imem_addr_o); else n_pass++;
    n_checks++; if ({sel_a_o, sel_b_o, sel_w_o} !== 6'd0) $display("FAIL reset_sel got %b want 000000", {sel_a_o, sel_b_o, sel_w_o}); else n_pass++;
    n_checks++; if ({reg_we_o, wb_sel_o, halted_o} !== 3'b000) $display("FAIL reset_ctl got %b want 000", {reg_we_o, wb_sel_o, halted_o}); else n_pass++;
    n_checks++; if (alu_op_o !== 3'd0) $display("FAIL reset_aluop got %0d want 0", alu_op_o); else n_pass++;
    step();
    step();
    rst_n_i = 1'b1;
    n_checks++; if (dut.state_q !== S_FETCH) $display("FAIL reset_state got %0d want %0d", dut.state_q, S_FETCH); else n_pass++;
  endtask

  task automatic test_ldi();
    clear_mem();
    mem[0] = 10'b0001_01_0101;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (reg_we_o !== (c == 4)) $display("FAIL ldi_we cycle %0d got %b want %b", c, reg_we_o, (c == 4)); else n_pass++;
      if (c == 4) begin
        n_checks++; if (sel_w_o !== 2'd1) $display("FAIL ldi_selw got %0d want 1", sel_w_o); else n_pass++;
        n_checks++; if (wb_sel_o !== 1'b1) $display("FAIL ldi_wbsel got %b want 1", wb_sel_o); else n_pass++;
        n_checks++; if (imm_o !== 4'd5) $display("FAIL ldi_imm got %0d want 5", imm_o); else n_pass++;
      end
      step();
    end
    n_checks++; if (imem_addr_o !== 4'd1) $display("FAIL ldi_pc got %0d want 1", imem_addr_o); else n_pass++;
  endtask

  task automatic test_add_jz();
    clear_mem();
    mem[0] = 10'b0011_01_10_00;
    mem[1] = 10'b1000_00_1001;
    do_reset();
    step();
    step();
    alu_zero_i = 1'b1;
    n_checks++; if (alu_op_o !== ALU_ADD) $display("FAIL add_exec_aluop got %0d want 0", alu_op_o); else n_pass++;
    step();
    alu_zero_i = 1'b0;
    n_checks++; if ({sel_a_o, sel_b_o} !== {2'd1, 2'd2}) $display("FAIL add_write_sel got a=%0d b=%0d want a=1 b=2", sel_a_o, sel_b_o); else n_pass++;
    n_checks++; if (alu_op_o !== ALU_ADD) $display("FAIL add_write_aluop got %0d want 0", alu_op_o); else n_pass++;
    n_checks++; if ({reg_we_o, wb_sel_o, sel_w_o} !== {1'b1, 1'b0, 2'd1}) $display("FAIL add_write_ctl got we=%b wb=%b w=%0d want we=1 wb=0 w=1", reg_we_o, wb_sel_o, sel_w_o); else n_pass++;
    step();
    n_checks++; if (imem_addr_o !== 4'd1) $display("FAIL jz_fetch_addr got %0d want 1", imem_addr_o); else n_pass++;
    step();
    step();
    n_checks++; if ({reg_we_o, imem_addr_o} !== {1'b0, 4'd2}) $display("FAIL jz_exec got we=%b pc=%0d want we=0 pc=2", reg_we_o, imem_addr_o); else n_pass++;
    step();
    n_checks++; if (imem_addr_o !== 4'd9) $display("FAIL jz_target got %0d want 9", imem_addr_o); else n_pass++;
  endtask

  task automatic test_jmp_self();
    logic [3:0] exp_addr;
    clear_mem();
    mem[0]  = 10'b0111_00_1111;
    mem[15] = 10'b0111_00_1111;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      if (c <= 2)                exp_addr = 4'd0;
      else if (c == 3)           exp_addr = 4'd1;
      else if ((c - 4) % 3 == 2) exp_addr = 4'd0;
      else                       exp_addr = 4'd15;
      n_checks++;
      if (imem_addr_o !== exp_addr || reg_we_o !== 1'b0)
        $display("FAIL jmp_loop cycle %0d got pc=%0d we=%b want pc=%0d we=0", c, imem_addr_o, reg_we_o, exp_addr);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_en_hold();
    clear_mem();
    mem[0] = 10'b0100_10_11_00;
    mem[1] = 10'b1000_00_1001;
    do_reset();
    step();
    step();
    en_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (imem_addr_o !== 4'd1 || alu_op_o !== ALU_SUB || sel_a_o !== 2'd2 || sel_b_o !== 2'd3 ||
          reg_we_o !== 1'b0 || dut.state_q !== S_EXEC)
        $display("FAIL en_hold %0d got pc=%0d op=%0d a=%0d b=%0d we=%b st=%0d want pc=1 op=1 a=2 b=3 we=0 st=%0d",
                 k, imem_addr_o, alu_op_o, sel_a_o, sel_b_o, reg_we_o, dut.state_q, S_EXEC);
      else n_pass++;
    end
    en_i = 1'b1;
    step();
    n_checks++; if ({reg_we_o, sel_w_o, wb_sel_o} !== {1'b1, 2'd2, 1'b0}) $display("FAIL en_resume_write got we=%b w=%0d wb=%b want we=1 w=2 wb=0", reg_we_o, sel_w_o, wb_sel_o); else n_pass++;
    en_i = 1'b0;
    #1;
    n_checks++; if (reg_we_o !== 1'b0) $display("FAIL en_gate_we got %b want 0", reg_we_o); else n_pass++;
    en_i = 1'b1;
    #1;
    n_checks++; if (reg_we_o !== 1'b1) $display("FAIL en_ungate_we got %b want 1", reg_we_o); else n_pass++;
    step();
    n_checks++; if (imem_addr_o !== 4'd1) $display("FAIL en_next_fetch got %0d want 1", imem_addr_o); else n_pass++;
    step();
    step();
    step();
    n_checks++; if (imem_addr_o !== 4'd2) $display("FAIL jz_not_taken got %0d want 2", imem_addr_o); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    clear_mem();
    mem[0] = 10'b0001_01_0101;
    do_reset();
    step();
    step();
    step();
    n_checks++; if (reg_we_o !== 1'b1) $display("FAIL rstw_pre_we got %b want 1", reg_we_o); else n_pass++;
    #3;
    rst_n_i = 1'b0;
    #1;
    n_checks++; if ({reg_we_o, imem_addr_o, sel_w_o} !== {1'b0, 4'd0, 2'd0}) $display("FAIL rstw_async got we=%b pc=%0d w=%0d want we=0 pc=0 w=0", reg_we_o, imem_addr_o, sel_w_o); else n_pass++;
    step();
    rst_n_i = 1'b1;
    n_checks++; if (dut.state_q !== S_FETCH || imem_addr_o !== 4'd0) $display("FAIL rstw_release got st=%0d pc=%0d want st=%0d pc=0", dut.state_q, imem_addr_o, S_FETCH); else n_pass++;
    step();
    step();
    step();
    n_checks++; if (reg_we_o !== 1'b1) $display("FAIL rstw_rerun_we got %b want 1", reg_we_o); else n_pass++;
  endtask

  task automatic test_illegal_halt();
    clear_mem();
    mem[0] = 10'b1010_00_0000;
    mem[1] = 10'b1111_00_0000;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (reg_we_o !== 1'b0) $display("FAIL illegal_we cycle %0d got %b want 0", c, reg_we_o); else n_pass++;
      step();
    end
    n_checks++; if (imem_addr_o !== 4'd1 || dut.state_q !== S_FETCH) $display("FAIL illegal_3cyc got pc=%0d st=%0d want pc=1 st=%0d", imem_addr_o, dut.state_q, S_FETCH); else n_pass++;
    step();
    step();
    n_checks++; if (halted_o !== 1'b0) $display("FAIL halt_exec got %b want 0", halted_o); else n_pass++;
    step();
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (halted_o !== 1'b1 || imem_addr_o !== 4'd2 || reg_we_o !== 1'b0)
        $display("FAIL halt_hold %0d got h=%b pc=%0d we=%b want h=1 pc=2 we=0", k, halted_o, imem_addr_o, reg_we_o);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add_jz();
    test_jmp_self();
    test_en_hold();
    test_reset_mid_write();
    test_illegal_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
